// File: rtl/alu_mdu_sequencer_if.sv
// Request/response handshake and shared-ALU hookup between the EX stage and the
// multi-cycle MUL/DIVU/REMU sequencer.
interface alu_mdu_sequencer_if #(
  parameter int XLEN = 32
);
  logic            ReqValid;
  logic            ReqReady;
  logic [1:0]      ReqOp;
  logic [XLEN-1:0] ReqA;
  logic [XLEN-1:0] ReqB;
  logic            Flush;
  logic            RespValid;
  logic            RespReady;
  logic [XLEN-1:0] RespData;
  logic [XLEN-1:0] AluOperand1;
  logic [XLEN-1:0] AluOperand2;
  logic [3:0]      AluContrlOut;
  logic [XLEN-1:0] AluResult;

  // The pipeline side issues requests and owns the ALU; the sequencer borrows it.
  modport master (
    output ReqValid, ReqOp, ReqA, ReqB, Flush, RespReady, AluResult,
    input  ReqReady, RespValid, RespData, AluOperand1, AluOperand2, AluContrlOut
  );

  modport slave (
    input  ReqValid, ReqOp, ReqA, ReqB, Flush, RespReady, AluResult,
    output ReqReady, RespValid, RespData, AluOperand1, AluOperand2, AluContrlOut
  );
endinterface

// File: rtl/alu_mdu_sequencer.sv
// Multi-cycle unsigned MUL (low word), DIVU and REMU built on the shared EX-stage
// ALU: shift-add multiply and restoring divide, one ALU operation per cycle.
module alu_mdu_sequencer #(
  parameter int         XLEN     = 32,
  parameter int         CNT_W    = 5,
  parameter logic [3:0] ALU_ADD  = 4'd3,
  parameter logic [3:0] ALU_SUB  = 4'd4,
  parameter logic [3:0] ALU_SLTU = 4'd9
) (
  input  logic                clk,
  input  logic                rst_n,
  alu_mdu_sequencer_if.slave  seq
);

  typedef enum logic [2:0] {IDLE, MUL_STEP, DIV_CMP, DIV_SUB, DONE} state_t;
  typedef enum logic [1:0] {OP_MUL = 2'b00, OP_DIVU = 2'b01, OP_REMU = 2'b10, OP_RSVD = 2'b11} op_t;

  state_t          state;
  op_t             op_q;
  logic [CNT_W-1:0] cnt;
  // a_q: multiplicand (MUL) or dividend shifting out / quotient shifting in (DIV)
  // b_q: multiplier (MUL) or divisor (DIV); acc_q: product (MUL) or remainder (DIV)
  logic [XLEN-1:0] a_q;
  logic [XLEN-1:0] b_q;
  logic [XLEN-1:0] acc_q;
  logic            ge_q;
  logic            req_ready;
  logic            resp_valid;
  logic [XLEN-1:0] resp_data;

  logic [XLEN-1:0] shifted;
  logic            quot_bit;
  logic            last_step;
  logic [XLEN-1:0] alu_op1;
  logic [XLEN-1:0] alu_op2;
  logic [3:0]      alu_ctrl;

  // Partial remainder with the next dividend bit brought in; its carry-out is acc_q[XLEN-1].
  assign shifted   = {acc_q[XLEN-2:0], a_q[XLEN-1]};
  assign quot_bit  = acc_q[XLEN-1] | ~seq.AluResult[0];
  assign last_step = &cnt;

  always_comb begin
    // NOTE: every output gets a default first so no path through the case infers a latch.
    alu_op1  = '0;
    alu_op2  = '0;
    alu_ctrl = ALU_ADD;
    case (state)
      MUL_STEP: begin
        alu_op1 = acc_q;
        alu_op2 = b_q[0] ? a_q : '0;
      end
      DIV_CMP: begin
        alu_op1  = shifted;
        alu_op2  = b_q;
        alu_ctrl = ALU_SLTU;
      end
      DIV_SUB: begin
        alu_op1  = acc_q;
        alu_op2  = ge_q ? b_q : '0;
        alu_ctrl = ALU_SUB;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    // NOTE: datapath registers are reset along with the FSM so an aborted operation leaves nothing stale.
    if (!rst_n) begin
      state      <= IDLE;
      op_q       <= OP_MUL;
      cnt        <= '0;
      a_q        <= '0;
      b_q        <= '0;
      acc_q      <= '0;
      ge_q       <= 1'b0;
      req_ready  <= 1'b1;
      resp_valid <= 1'b0;
      resp_data  <= '0;
    end else if (seq.Flush) begin
      state      <= IDLE;
      req_ready  <= 1'b1;
      resp_valid <= 1'b0;
    end else begin
      // NOTE: non-blocking updates so every register sees pre-edge values of the others.
      case (state)
        IDLE: begin
          if (seq.ReqValid) begin
            a_q       <= seq.ReqA;
            b_q       <= seq.ReqB;
            op_q      <= op_t'(seq.ReqOp);
            cnt       <= '0;
            acc_q     <= '0;
            ge_q      <= 1'b0;
            req_ready <= 1'b0;
            case (op_t'(seq.ReqOp))
              OP_MUL:           state <= MUL_STEP;
              OP_DIVU, OP_REMU: state <= DIV_CMP;
              default: begin
                state     <= DONE;
                resp_data <= '0;
              end
            endcase
          end
        end
        MUL_STEP: begin
          acc_q <= seq.AluResult;
          a_q   <= a_q << 1;
          b_q   <= b_q >> 1;
          cnt   <= cnt + 1'b1;
          if (last_step) begin
            state     <= DONE;
            resp_data <= seq.AluResult;
          end
        end
        DIV_CMP: begin
          ge_q  <= quot_bit;
          acc_q <= shifted;
          a_q   <= {a_q[XLEN-2:0], quot_bit};
          state <= DIV_SUB;
        end
        DIV_SUB: begin
          acc_q <= seq.AluResult;
          cnt   <= cnt + 1'b1;
          if (last_step) begin
            state     <= DONE;
            resp_data <= (op_q == OP_REMU) ? seq.AluResult : a_q;
          end else begin
            state <= DIV_CMP;
          end
        end
        DONE: begin
          // First DONE cycle only raises RespValid; the handshake is taken from then on.
          if (!resp_valid) begin
            resp_valid <= 1'b1;
          end else if (seq.RespReady) begin
            resp_valid <= 1'b0;
            req_ready  <= 1'b1;
            state      <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign seq.ReqReady     = req_ready;
  assign seq.RespValid    = resp_valid;
  assign seq.RespData     = resp_data;
  assign seq.AluOperand1  = alu_op1;
  assign seq.AluOperand2  = alu_op2;
  assign seq.AluContrlOut = alu_ctrl;

endmodule

// File: doc/alu_mdu_sequencer.md
Name: alu_mdu_sequencer

Overview:
Multi-cycle sequencer that reuses the shared 32-bit ALU to run M-extension-style unsigned MUL (low 32 bits), DIVU and REMU. Iterates shift-add and restoring-divide steps, driving ALU operands and control each cycle and capturing the ALU result on the next clock edge. Sits beside the EX stage. The pipeline stalls on ReqReady/RespValid while the sequencer owns the ALU through an EX-stage mux.

Parameters:
XLEN, 32, operand/result width (fixed, only 32 supported)
CNT_W, 5, iteration counter width (XLEN = 2^CNT_W)

Ports:
clk  input  1  clock, all state on rising edge
rst_n  input  1  asynchronous active-low reset
ReqValid  input  1  request present
ReqReady  output  1  sequencer idle, can accept
ReqOp  input  2  00 MUL, 01 DIVU, 10 REMU, 11 reserved
ReqA  input  32  multiplicand / dividend
ReqB  input  32  multiplier / divisor
Flush  input  1  synchronous abort of current operation
RespValid  output  1  result available
RespReady  input  1  consumer takes result
RespData  output  32  result
AluOperand1  output  32  to shared ALU Operand1
AluOperand2  output  32  to shared ALU Operand2
AluContrlOut  output  4  to shared ALU control (`ADD/`SUB/`SLTU codes from Parameters.v)
AluResult  input  32  combinational ALU output, same cycle

Behaviour:
- Reset (rst_n low, async): state IDLE, ReqReady=1, RespValid=0, RespData=0, AluOperand1=AluOperand2=0, AluContrlOut=`ADD. Reset mid-operation discards all progress.
- States: IDLE, MUL_STEP, DIV_CMP, DIV_SUB, DONE. ReqReady=1 only in IDLE.
- Accept: ReqValid&ReqReady at edge T latches A, B, op; cnt=0; acc/R=0. MUL->MUL_STEP, DIVU/REMU->DIV_CMP, reserved->DONE with RespData=0.
- MUL_STEP: Operand1=acc, Operand2=mlier[0]?mcand:0, ctrl `ADD. Edge: acc<=AluResult, mcand<<=1, mlier>>=1, cnt++. After cnt=31 -> DONE. Result = acc (mod 2^32).
- DIV_CMP: S={R[30:0],Q[31]}. Operand1=S, Operand2=D, ctrl `SLTU. Edge: ge<=R[31] | ~AluResult[0] (R[31] covers the 33-bit overflow case); R<=S; Q<={Q[30:0],ge}. -> DIV_SUB.
- DIV_SUB: Operand1=R, Operand2=ge?D:0, ctrl `SUB. Edge: R<=AluResult, cnt++. cnt=31 -> DONE, else DIV_CMP.
- DIVU result = Q; REMU result = R. Divide by zero needs no special case: Q=0xFFFFFFFF, R=dividend (RISC-V semantics).
- Latency: MUL RespValid first high after edge T+33. DIVU/REMU after T+65. Reserved after T+1.
- DONE: RespValid=1, RespData stable until RespValid&RespReady edge -> IDLE. A new request is accepted no earlier than the cycle after return to IDLE.
- Idle/DONE ALU drive: Operand1=Operand2=0, ctrl `ADD.
- Flush: any state -> IDLE next edge, RespValid=0, result dropped. Flush with ReqValid in IDLE: request not accepted (flush wins). Flush and RespReady in DONE: the result counts as consumed, no second response.
- ReqA/ReqB/ReqOp are ignored after the accept edge; changes do not affect the result.
- Outputs are registered or decoded from state only. No combinational path from ReqValid/RespReady to ALU ports.

Test Plan:
- MUL A=7 B=6, RespReady=1: RespData=42, RespValid rises after edge T+33, high one cycle.
- MUL A=0xFFFFFFFF B=0xFFFFFFFF -> 0x00000001. MUL A=0x12345678 B=0 -> 0.
- DIVU 100/7 -> 14 at T+65. REMU 100/7 -> 2. DIVU 0xFFFFFFFF/0x80000001 -> 1, REMU -> 0x7FFFFFFE (carry path).
- DIVU 0x1234/0 -> 0xFFFFFFFF. REMU 0x1234/0 -> 0x1234. Reserved op 11 -> RespData=0 at T+1.
- Backpressure: RespReady low 10 cycles in DONE -> RespValid/RespData held, ReqReady=0. RespReady high -> IDLE, ReqReady=1 next cycle.
- Flush at cycle 20 of DIVU -> IDLE next edge, no RespValid. rst_n low mid-MUL -> all outputs at reset values immediately (async). Follow-up MUL 3*5 -> 15.
